// File: rtl/spi_slave_responder_pkg.sv
// Shared definitions for the SPI mode-0 slave responder: FSM encoding, defaults and pin idle levels.
package spi_slave_responder_pkg;

    localparam int unsigned DEFAULT_DATA_W      = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // Mode 0: sclk idles low; chip select idles deasserted (high)
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-flop rise/fall detector.
module spi_sync_edge
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned STAGES  = DEFAULT_SYNC_STAGES,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled pins, MSB-first rx/tx shifting, one-byte tx holding buffer.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_underrun
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic sclk_rise_c, sclk_fall_c;
    logic cs_rise_c, cs_fall_c;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (cs_n),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    // mosi needs no edge detect; same depth keeps it aligned with the sclk edge pulses
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mosi_sync_q <= '0;
        else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
    logic               miso_q, miso_d;
    logic               underrun_q, underrun_d;
    logic               byte_done_q, byte_done_d;
    logic [DATA_W-1:0]  buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic               load_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            underrun_q  <= 1'b0;
            byte_done_q <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            underrun_q  <= underrun_d;
            byte_done_q <= byte_done_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        underrun_d  = 1'b0;
        byte_done_d = byte_done_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        load_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                miso_d      = 1'b0;
                bit_cnt_d   = '0;
                byte_done_d = 1'b0;
                if (cs_fall_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else begin
                    load_c  = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // cs_n release has priority over any coincident sclk edge
                if (cs_rise_c) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    miso_d      = 1'b0;
                    byte_done_d = 1'b0;
                end else if (sclk_rise_c) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d   = rx_shift_d;
                        rx_valid_d  = 1'b1;
                        bit_cnt_d   = '0;
                        byte_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_c) begin
                    if (byte_done_q) begin
                        load_c      = 1'b1;
                        byte_done_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        miso_d     = tx_shift_d[DATA_W-1];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Next tx word comes from the holding buffer, or zeros when it is empty
        if (load_c) begin
            tx_shift_d = buf_full_q ? buf_q : '0;
            underrun_d = ~buf_full_q;
            buf_full_d = 1'b0;
            miso_d     = tx_shift_d[DATA_W-1];
        end

        // Accept only into an empty buffer; a same-cycle load never bypasses it
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    assign miso        = miso_q;
    assign busy        = (state_q != ST_IDLE);
    assign miso_oe     = busy;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder acting as an SPI mode-0 master at sclk = clk/8.
module tb_spi_slave_responder;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              sclk, cs_n, mosi;
    logic              miso, miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid, tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, busy, tx_underrun;

    int vecs = 0;
    int errs = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;

    spi_slave_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt <= rxv_cnt + 1;
        if (tx_underrun) und_cnt <= und_cnt + 1;
    end

    task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vecs++; if (miso !== 1'b0)     begin errs++; $display("FAIL reset_miso got=%b exp=0", miso); end
        vecs++; if (miso_oe !== 1'b0)  begin errs++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
        vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vecs++; if (tx_underrun !== 1'b0) begin errs++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        int r0, u0;
        push_tx(8'hA5);
        vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL single_accept tx_ready got=%b exp=0", tx_ready); end
        r0 = rxv_cnt; u0 = und_cnt;
        frame_start();
        vecs++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin errs++; $display("FAIL single_busy got=%b/%b exp=1/1", busy, miso_oe); end
        vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL single_tx_ready_back got=%b exp=1", tx_ready); end
        vecs++; if (und_cnt - u0 !== 0) begin errs++; $display("FAIL single_no_underrun got=%0d exp=0", und_cnt - u0); end
        spi_xfer(8'h3C, mi);
        vecs++; if (mi !== 8'hA5) begin errs++; $display("FAIL single_miso got=%h exp=a5", mi); end
        vecs++; if (rx_data !== 8'h3C) begin errs++; $display("FAIL single_rx_data got=%h exp=3c", rx_data); end
        vecs++; if (rxv_cnt - r0 !== 1) begin errs++; $display("FAIL single_rx_valid_pulses got=%0d exp=1", rxv_cnt - r0); end
        frame_end();
        vecs++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin errs++; $display("FAIL single_idle got=%b/%b exp=0/0", miso_oe, miso); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        int r0;
        push_tx(8'h81);
        r0 = rxv_cnt;
        frame_start();
        push_tx(8'h7E);
        spi_xfer(8'h12, mi);
        vecs++; if (mi !== 8'h81) begin errs++; $display("FAIL b2b_miso0 got=%h exp=81", mi); end
        vecs++; if (rx_data !== 8'h12) begin errs++; $display("FAIL b2b_rx0 got=%h exp=12", rx_data); end
        spi_xfer(8'h34, mi);
        vecs++; if (mi !== 8'h7E) begin errs++; $display("FAIL b2b_miso1 got=%h exp=7e", mi); end
        vecs++; if (rx_data !== 8'h34) begin errs++; $display("FAIL b2b_rx1 got=%h exp=34", rx_data); end
        vecs++; if (rxv_cnt - r0 !== 2) begin errs++; $display("FAIL b2b_rx_valid_pulses got=%0d exp=2", rxv_cnt - r0); end
        frame_end();
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        int u0;
        vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL underrun_empty got=%b exp=1", tx_ready); end
        u0 = und_cnt;
        frame_start();
        vecs++; if (und_cnt - u0 !== 1) begin errs++; $display("FAIL underrun_pulses got=%0d exp=1", und_cnt - u0); end
        spi_xfer(8'h99, mi);
        vecs++; if (mi !== 8'h00) begin errs++; $display("FAIL underrun_miso got=%h exp=00", mi); end
        vecs++; if (rx_data !== 8'h99) begin errs++; $display("FAIL underrun_rx got=%h exp=99", rx_data); end
        frame_end();
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int r0;
        r0 = rxv_cnt;
        frame_start();
        mosi = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sclk = ~sclk;
            repeat (4) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        vecs++; if (miso_oe !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_oe got=%b/%b exp=0/0", miso_oe, busy); end
        vecs++; if (rxv_cnt - r0 !== 0) begin errs++; $display("FAIL abort_rx_valid got=%0d exp=0", rxv_cnt - r0); end
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        r0 = rxv_cnt;
        frame_start();
        spi_xfer(8'hF0, mi);
        vecs++; if (rx_data !== 8'hF0) begin errs++; $display("FAIL abort_next_rx got=%h exp=f0", rx_data); end
        vecs++; if (rxv_cnt - r0 !== 1) begin errs++; $display("FAIL abort_next_pulses got=%0d exp=1", rxv_cnt - r0); end
        frame_end();
    endtask

    task automatic test_reset_mid();
        push_tx(8'h3A);
        frame_start();
        push_tx(8'h66);
        vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL midrst_full got=%b exp=0", tx_ready); end
        mosi = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sclk = ~sclk;
            repeat (4) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        vecs++; if (miso_oe !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL midrst_oe got=%b/%b exp=0/0", miso_oe, busy); end
        vecs++; if (miso !== 1'b0) begin errs++; $display("FAIL midrst_miso got=%b exp=0", miso); end
        vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL midrst_tx_ready got=%b exp=1", tx_ready); end
        vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
        vecs++; if (rx_valid !== 1'b0 || tx_underrun !== 1'b0) begin errs++; $display("FAIL midrst_pulses got=%b/%b exp=0/0", rx_valid, tx_underrun); end
        @(negedge clk);
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL midrst_buf_empty got=%b exp=1", tx_ready); end
    endtask

    task automatic test_buffer_full();
        logic [7:0] mi;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'hCC;
        repeat (3) @(negedge clk);
        vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL full_hold got=%b exp=0", tx_ready); end
        frame_start();
        vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL full_second_accepted got=%b exp=0", tx_ready); end
        tx_valid = 1'b0;
        spi_xfer(8'hA0, mi);
        vecs++; if (mi !== 8'h55) begin errs++; $display("FAIL full_miso0 got=%h exp=55", mi); end
        spi_xfer(8'h0B, mi);
        vecs++; if (mi !== 8'hCC) begin errs++; $display("FAIL full_miso1 got=%h exp=cc", mi); end
        vecs++; if (rx_data !== 8'h0B) begin errs++; $display("FAIL full_rx got=%h exp=0b", rx_data); end
        frame_end();
    endtask

    initial begin
        reset    = 1'b1;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_buffer_full();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
